// File: rtl/bram_rd_pkg.sv
// Shared types for the BRAM stream reader: sweep states, default
// geometry and the buffered stream entry.
package bram_rd_pkg;

  localparam int DEF_AWIDTH = 10;
  localparam int DEF_DWIDTH = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_t;

  typedef struct packed {
    logic [DEF_DWIDTH-1:0] data;
    logic                  last;
  } fifo_entry_t;

endpackage

// File: rtl/bram_rd_fifo.sv
// Small synchronous FIFO holding landed BRAM words until the stream
// consumer accepts them; head entry is read straight from storage flops.
module bram_rd_fifo
  import bram_rd_pkg::*;
#(
  parameter int WIDTH = DEF_DWIDTH + 1,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [CW-1:0]    r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wp] <= i_data;
        r_wp        <= r_wp + 1'b1;
      end
      if (i_pop) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
    end
  end

  assign o_data  = r_mem[r_rp];
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;

endmodule

// File: rtl/bram_stream_reader.sv
// Sweeps BRAM port A over 0..last_addr and streams the words out,
// issuing only while in-flight reads plus buffered words fit the FIFO.
module bram_stream_reader
  import bram_rd_pkg::*;
#(
  parameter int DWIDTH     = DEF_DWIDTH,
  parameter int AWIDTH     = DEF_AWIDTH,
  parameter int RD_LATENCY = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [AWIDTH-1:0] last_addr,
  output logic              bram_en_a,
  output logic              bram_we,
  output logic [AWIDTH-1:0] bram_addr,
  output logic [DWIDTH-1:0] bram_wr_data,
  input  logic [DWIDTH-1:0] bram_rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DWIDTH-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              done,
  output logic [15:0]       wrap_count
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  state_t                r_state, w_state_nx;
  logic [AWIDTH-1:0]     r_addr, w_addr_nx;
  logic [AWIDTH-1:0]     r_last_addr;
  logic                  r_loop;
  logic [15:0]           r_wrap, w_wrap_nx;
  logic                  r_done, w_done_nx;
  logic [RD_LATENCY-1:0] r_vld, r_lst;
  logic                  w_issue, w_at_last, w_pop, w_empty, w_credit;
  logic [CW-1:0]         w_count;
  logic [CW:0]           w_infl, w_outst;
  logic [DWIDTH:0]       w_head;

  bram_rd_fifo #(
    .WIDTH (DWIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_vld[RD_LATENCY-1]),
    .i_data  ({bram_rd_data, r_lst[RD_LATENCY-1]}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_comb begin
    w_infl = '0;
    for (int i = 0; i < RD_LATENCY; i++)
      w_infl = w_infl + (CW+1)'(r_vld[i]);
  end

  // Outstanding is measured after this cycle's pop so a full FIFO
  // being drained still lets a read issue in the same cycle.
  assign w_pop     = !w_empty && m_ready;
  assign w_outst   = w_infl + {1'b0, w_count} - (CW+1)'(w_pop);
  assign w_credit  = w_outst < (CW+1)'(FIFO_DEPTH);
  assign w_at_last = (r_addr == r_last_addr);

  always_comb begin
    w_state_nx = r_state;
    w_addr_nx  = r_addr;
    w_wrap_nx  = r_wrap;
    w_issue    = 1'b0;
    w_done_nx  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nx = ST_RUN;
          w_addr_nx  = '0;
          w_wrap_nx  = '0;
        end
      end
      ST_RUN: begin
        if (stop) begin
          w_state_nx = ST_DRAIN;
        end else if (w_credit) begin
          w_issue = 1'b1;
          if (w_at_last) begin
            w_addr_nx = '0;
            if (!r_loop)
              w_state_nx = ST_DRAIN;
            else if (r_wrap != 16'hFFFF)
              w_wrap_nx = r_wrap + 16'd1;
          end else begin
            w_addr_nx = r_addr + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (w_outst == '0) begin
          w_state_nx = ST_IDLE;
          w_done_nx  = 1'b1;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_last_addr <= '0;
      r_loop      <= 1'b0;
      r_wrap      <= '0;
      r_done      <= 1'b0;
      r_vld       <= '0;
      r_lst       <= '0;
    end else begin
      r_state <= w_state_nx;
      r_addr  <= w_addr_nx;
      r_wrap  <= w_wrap_nx;
      r_done  <= w_done_nx;
      r_vld   <= (r_vld << 1) | RD_LATENCY'(w_issue);
      r_lst   <= (r_lst << 1) | RD_LATENCY'(w_issue && w_at_last);
      if (r_state == ST_IDLE && start) begin
        r_last_addr <= last_addr;
        r_loop      <= loop_en;
      end
    end
  end

  assign bram_en_a    = w_issue;
  assign bram_we      = 1'b0;
  assign bram_addr    = r_addr;
  assign bram_wr_data = '0;
  assign m_valid      = !w_empty;
  assign m_data       = w_head[DWIDTH:1];
  assign m_last       = w_head[0];
  assign busy         = (r_state != ST_IDLE);
  assign done         = r_done;
  assign wrap_count   = r_wrap;

endmodule

// File: tb/tb_bram_stream_reader.sv
// Drives two readers (read latency 1 and 2) with one stimulus and
// checks each against a sweep/stream reference model.
module tb_bram_stream_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, stop = 1'b0, loop_en = 1'b0, m_ready = 1'b1;
  logic [9:0]  last_addr = '0;

  logic        en [2], we [2], mv [2], ml [2], bz [2], dn [2];
  logic [9:0]  addr [2];
  logic [63:0] wd [2], rdat [2], md [2];
  logic [15:0] wc [2];

  logic [63:0] mem [2][1024];
  logic [63:0] p1a, p1b, p2b;

  int checks = 0, errors = 0;
  int cyc_n = 0, start_c = 0, lst_m = 0, rmode = 0;
  bit cont = 0;
  int nxt_iss [2], nxt_out [2], n_en [2], n_out [2], n_done [2];
  int last_hs [2], first_en [2], first_v [2];
  bit hold_v [2];
  logic [63:0] hold_d [2];

  always #5 clk = ~clk;

  bram_stream_reader #(.RD_LATENCY(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .loop_en(loop_en), .last_addr(last_addr),
    .bram_en_a(en[0]), .bram_we(we[0]), .bram_addr(addr[0]),
    .bram_wr_data(wd[0]), .bram_rd_data(rdat[0]),
    .m_valid(mv[0]), .m_ready(m_ready), .m_data(md[0]), .m_last(ml[0]),
    .busy(bz[0]), .done(dn[0]), .wrap_count(wc[0])
  );

  bram_stream_reader #(.RD_LATENCY(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .loop_en(loop_en), .last_addr(last_addr),
    .bram_en_a(en[1]), .bram_we(we[1]), .bram_addr(addr[1]),
    .bram_wr_data(wd[1]), .bram_rd_data(rdat[1]),
    .m_valid(mv[1]), .m_ready(m_ready), .m_data(md[1]), .m_last(ml[1]),
    .busy(bz[1]), .done(dn[1]), .wrap_count(wc[1])
  );

  // Port A models: one output register, plus a second stage for latency 2.
  always @(posedge clk) begin
    if (en[0]) p1a <= mem[0][addr[0]];
    if (en[1]) p1b <= mem[1][addr[1]];
    p2b <= p1b;
  end
  assign rdat[0] = p1a;
  assign rdat[1] = p2b;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      nxt_iss[d] = 0; nxt_out[d] = 0; n_en[d] = 0; n_out[d] = 0;
      n_done[d] = 0; last_hs[d] = -10; first_en[d] = -1;
      first_v[d] = -1; hold_v[d] = 0;
    end
  endtask

  // One clock: sample at negedge, score, then advance past posedge.
  task automatic cyc();
    @(negedge clk);
    cyc_n++;
    for (int d = 0; d < 2; d++) begin
      if (en[d]) begin
        chk($sformatf("issue_addr d%0d", d), 64'(addr[d]), 64'(nxt_iss[d]));
        nxt_iss[d] = (nxt_iss[d] == lst_m) ? 0 : nxt_iss[d] + 1;
        n_en[d]++;
        if (first_en[d] < 0) first_en[d] = cyc_n;
      end
      if (mv[d] && first_v[d] < 0) first_v[d] = cyc_n;
      if (hold_v[d] && mv[d])
        chk($sformatf("stall_hold d%0d", d), md[d], hold_d[d]);
      if (mv[d] && m_ready) begin
        chk($sformatf("data d%0d", d), md[d], mem[d][nxt_out[d]]);
        chk($sformatf("last d%0d", d), 64'(ml[d]), 64'(nxt_out[d] == lst_m));
        nxt_out[d] = (nxt_out[d] == lst_m) ? 0 : nxt_out[d] + 1;
        n_out[d]++;
        last_hs[d] = cyc_n;
      end
      hold_v[d] = mv[d] && !m_ready;
      hold_d[d] = md[d];
      if (cont && first_v[d] >= 0)
        chk($sformatf("no_gap d%0d", d), 64'(mv[d]), 64'd1);
      chk($sformatf("credit d%0d", d), 64'(n_en[d] - n_out[d] <= 4), 64'd1);
      if (dn[d]) begin
        n_done[d]++;
        chk($sformatf("done_busy d%0d", d), 64'(bz[d]), 64'd0);
        chk($sformatf("done_after_hs d%0d", d), 64'(cyc_n), 64'(last_hs[d] + 1));
      end
    end
    @(posedge clk);
    #1;
    unique case (rmode)
      0: m_ready = 1'b1;
      1: m_ready = (cyc_n % 4 == 0) || (cyc_n % 4 == 3);
      2: m_ready = 1'($urandom % 2);
      default: m_ready = 1'b0;
    endcase
  endtask

  task automatic begin_sweep(int la, bit lp, bit with_stop);
    model_clear();
    last_addr = 10'(la); loop_en = lp; lst_m = la;
    start = 1'b1; stop = with_stop;
    cyc();
    start_c = cyc_n;
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic finish_sweep(string tag, int budget);
    int k = 0;
    while ((n_done[0] == 0 || n_done[1] == 0) && k < budget) begin
      cyc();
      k++;
    end
    cyc();
    cyc();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s done_once d%0d", tag, d), 64'(n_done[d]), 64'd1);
      chk($sformatf("%s no_loss d%0d", tag, d), 64'(n_out[d]), 64'(n_en[d]));
      chk($sformatf("%s idle d%0d", tag, d), 64'(bz[d]), 64'd0);
    end
  endtask

  task automatic stop_now(int exp_en, int exp_wc);
    stop = 1'b1;
    cont = 0;
    cyc();
    stop = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("stop_issues d%0d", d), 64'(n_en[d]), 64'(exp_en));
      if (exp_wc >= 0)
        chk($sformatf("stop_wrap d%0d", d), 64'(wc[d]), 64'(exp_wc));
    end
  endtask

  initial begin
    int la, n;
    for (int d = 0; d < 2; d++)
      for (int a = 0; a < 1024; a++)
        mem[d][a] = {$urandom, $urandom};
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_valid d%0d", d), 64'(mv[d]), 64'd0);
      chk($sformatf("rst_busy d%0d", d), 64'(bz[d]), 64'd0);
      chk($sformatf("rst_wrap d%0d", d), 64'(wc[d]), 64'd0);
      chk($sformatf("rst_data d%0d", d), md[d], 64'd0);
    end
    rst_n = 1'b1;
    cyc();

    // Basic four-word sweep with latency and contiguity checks.
    begin_sweep(3, 0, 0);
    finish_sweep("T1", 40);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("T1 en_lat d%0d", d), 64'(first_en[d] - start_c), 64'd1);
      chk($sformatf("T1 v_lat d%0d", d), 64'(first_v[d] - start_c), 64'(d + 3));
      chk($sformatf("T1 span d%0d", d), 64'(last_hs[d] - first_v[d]), 64'd3);
      chk($sformatf("T1 enables d%0d", d), 64'(n_en[d]), 64'd4);
      chk($sformatf("T1 wrap d%0d", d), 64'(wc[d]), 64'd0);
      chk($sformatf("T1 we d%0d", d), 64'(we[d]), 64'd0);
    end

    // Backpressure with a 1,0,0,1 ready pattern.
    rmode = 1;
    la = $urandom_range(3, 12);
    begin_sweep(la, 0, 0);
    finish_sweep("T2", 200);
    for (int d = 0; d < 2; d++)
      chk($sformatf("T2 enables d%0d", d), 64'(n_en[d]), 64'(la + 1));

    // Looping, full throughput across wraps, then stop.
    rmode = 0; m_ready = 1'b1;
    begin_sweep(7, 1, 0);
    cont = 1;
    repeat (40) cyc();
    stop_now(40, 5);
    finish_sweep("T3", 40);

    // Randomised looping sweeps with random ready and random stop.
    for (int r = 0; r < 3; r++) begin
      rmode = 2;
      la = $urandom_range(1, 20);
      n = $urandom_range(20, 60);
      begin_sweep(la, 1, 0);
      repeat (n) cyc();
      stop = 1'b1;
      cyc();
      stop = 1'b0;
      finish_sweep($sformatf("R%0d", r), 100);
    end

    // Boundaries: single word, then full address range with wrap.
    rmode = 0; m_ready = 1'b1;
    begin_sweep(0, 0, 0);
    finish_sweep("B0", 30);
    for (int d = 0; d < 2; d++)
      chk($sformatf("B0 enables d%0d", d), 64'(n_en[d]), 64'd1);
    begin_sweep(1023, 1, 0);
    repeat (1030) cyc();
    stop_now(1030, 1);
    finish_sweep("B1", 40);

    // start while running is ignored.
    begin_sweep(5, 0, 0);
    cyc();
    cyc();
    start = 1'b1; last_addr = 10'd2;
    cyc();
    start = 1'b0;
    finish_sweep("S1", 40);
    for (int d = 0; d < 2; d++)
      chk($sformatf("S1 enables d%0d", d), 64'(n_en[d]), 64'd6);

    // start together with stop in IDLE begins a sweep at address 0.
    begin_sweep(2, 0, 1);
    finish_sweep("S2", 40);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("S2 enables d%0d", d), 64'(n_en[d]), 64'd3);
      chk($sformatf("S2 en_lat d%0d", d), 64'(first_en[d] - start_c), 64'd1);
    end

    // Async reset with a full FIFO and no ready.
    rmode = 3; m_ready = 1'b0;
    begin_sweep(15, 1, 0);
    repeat (10) cyc();
    for (int d = 0; d < 2; d++)
      chk($sformatf("X full d%0d", d), 64'(n_en[d]), 64'd4);
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("X valid d%0d", d), 64'(mv[d]), 64'd0);
      chk($sformatf("X data d%0d", d), md[d], 64'd0);
      chk($sformatf("X last d%0d", d), 64'(ml[d]), 64'd0);
      chk($sformatf("X en d%0d", d), 64'(en[d]), 64'd0);
      chk($sformatf("X addr d%0d", d), 64'(addr[d]), 64'd0);
      chk($sformatf("X busy d%0d", d), 64'(bz[d]), 64'd0);
      chk($sformatf("X done d%0d", d), 64'(dn[d]), 64'd0);
      chk($sformatf("X wrap d%0d", d), 64'(wc[d]), 64'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
    rmode = 0; m_ready = 1'b1;
    repeat (6) begin
      cyc();
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("X post_valid d%0d", d), 64'(mv[d]), 64'd0);
        chk($sformatf("X post_en d%0d", d), 64'(n_en[d]), 64'd0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
